// File: rtl/rom_arb_pkg.sv
// Shared types and helpers for the ROM arbiter: port ids, response record, address check.
package rom_arb_pkg;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_e;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] data;
  } rom_rsp_t;

  localparam logic [31:0] ROM_WORD_BYTES = 32'd4;

  // Misaligned, or past the last populated word.
  function automatic logic addr_bad(input logic [31:0] addr, input logic [31:0] rom_bytes);
    return (addr[1:0] != 2'b00) || (addr > (rom_bytes - ROM_WORD_BYTES));
  endfunction

endpackage

// File: rtl/rom_arbiter_if.sv
// Request/response bundle for the I-port and D-port of the ROM arbiter.
interface rom_arbiter_if;

  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        i_err;

  logic        d_req;
  logic [31:0] d_addr;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;

  modport master (
    output i_req, i_addr, d_req, d_addr,
    input  i_gnt, i_rvalid, i_rdata, i_err,
    input  d_gnt, d_rvalid, d_rdata, d_err
  );

  modport slave (
    input  i_req, i_addr, d_req, d_addr,
    output i_gnt, i_rvalid, i_rdata, i_err,
    output d_gnt, d_rvalid, d_rdata, d_err
  );

endinterface

// File: rtl/rom_arb_rsp_reg.sv
// Per-port response register: captures ROM word or error on the edge after a grant.
// Latency 1 cycle; no backpressure, valid is a single-cycle pulse and data holds otherwise.
module rom_arb_rsp_reg
  import rom_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        capture,
  input  logic        err,
  input  logic [31:0] rom_val,
  output rom_rsp_t    rsp
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp <= '0;
    end else begin
      rsp.valid <= capture;
      rsp.err   <= capture & err;
      // Bad accesses return zero so a ROM default-arm X never leaks out.
      if (capture) begin
        rsp.data <= err ? 32'h0 : rom_val;
      end
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// Two-port (fetch/load) arbiter for a combinational ROM; optional round-robin via ROM_ARB_RR_EN.
// Latency: grant same cycle, response 1 cycle later; backpressure: loser sees gnt=0 and holds req.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter logic [31:0] ROM_BYTES = 32'hF0,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  rom_arbiter_if.slave     bus,
  output logic [31:0]      rom_addr,
  input  logic [31:0]      rom_val,
  output logic [CNT_W-1:0] conflict_cnt
);

  logic        conflict;
  logic        d_win;
  logic [31:0] sel_addr;
  logic        sel_bad;
  rom_rsp_t    i_rsp;
  rom_rsp_t    d_rsp;

  assign conflict = bus.i_req & bus.d_req;

`ifdef ROM_ARB_RR_EN
  port_e last_gnt;

  // Reset to D so the first conflict goes to the I-port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt <= PORT_D;
    end else if (conflict) begin
      last_gnt <= (last_gnt == PORT_D) ? PORT_I : PORT_D;
    end
  end

  always_comb begin
    d_win = bus.d_req & (~bus.i_req | (last_gnt == PORT_I));
  end
`else
  always_comb begin
    d_win = bus.d_req;
  end
`endif

  assign bus.d_gnt = ~rst & d_win;
  assign bus.i_gnt = ~rst & bus.i_req & ~d_win;

  always_comb begin
    sel_addr = 32'h0;
    if (bus.d_gnt) begin
      sel_addr = bus.d_addr;
    end else if (bus.i_gnt) begin
      sel_addr = bus.i_addr;
    end
  end

  assign rom_addr = {sel_addr[31:2], 2'b00};
  assign sel_bad  = addr_bad(sel_addr, ROM_BYTES);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt <= '0;
    end else if (conflict && (conflict_cnt != '1)) begin
      conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

  rom_arb_rsp_reg u_i_rsp (
    .clk     (clk),
    .rst     (rst),
    .capture (bus.i_gnt),
    .err     (sel_bad),
    .rom_val (rom_val),
    .rsp     (i_rsp)
  );

  rom_arb_rsp_reg u_d_rsp (
    .clk     (clk),
    .rst     (rst),
    .capture (bus.d_gnt),
    .err     (sel_bad),
    .rom_val (rom_val),
    .rsp     (d_rsp)
  );

  assign bus.i_rvalid = i_rsp.valid;
  assign bus.i_err    = i_rsp.err;
  assign bus.i_rdata  = i_rsp.data;
  assign bus.d_rvalid = d_rsp.valid;
  assign bus.d_err    = d_rsp.err;
  assign bus.d_rdata  = d_rsp.data;

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Arbitrates the single combinational instruction ROM between two requesters: the instruction-fetch stage (I-port) and the load path of the memory stage (D-port), which serves `lw` from ROM addresses. Each cycle it grants at most one request, drives the ROM address, and returns the registered read word to the granted port one cycle later. It also flags misaligned and out-of-range accesses and counts arbitration conflicts for debug. It sits between the core's fetch and memory stages and the `ROM` instance.

## Interface
- `ROM_BYTES`, default 32'hF0: size of the populated ROM in bytes; valid word addresses are 0 .. ROM_BYTES-4.
- `CNT_W`, default 16: width of the conflict counter.

- `clk`  in  1  system clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `i_req`  in  1  I-port read request
- `i_addr`  in  32  I-port byte address
- `i_gnt`  out  1  I-port request accepted this cycle
- `i_rvalid`  out  1  I-port response valid
- `i_rdata`  out  32  I-port read word
- `i_err`  out  1  I-port response is an error (qualified by `i_rvalid`)
- `d_req`, `d_addr`, `d_gnt`, `d_rvalid`, `d_rdata`, `d_err`: same as the I-port signals, for the D-port
- `rom_addr`  out  32  address to the ROM
- `rom_val`  in  32  ROM data (combinational from `rom_addr`)
- `conflict_cnt`  out  CNT_W  number of cycles in which both ports requested; saturates

## Operation
- Request/grant: a requester holds `x_req` and `x_addr` stable until `x_gnt` is sampled high. A grant is combinational in the same cycle as the request. Grant is a single-cycle acceptance.
- Arbitration, default: the D-port has fixed priority over the I-port. When only one port requests, that port is granted.
- `rom_addr` = granted port's address with bits [1:0] forced to 0, or 0 when there is no grant.
- Address check on the granted address:
  - misaligned if addr[1:0] != 0;
  - out-of-range if addr > ROM_BYTES-4.
- Response: on the edge following a grant, the granted port's `x_rvalid` goes to 1 for exactly one cycle.
  - On a good access, `x_rdata` = `rom_val`, captured at that edge, and `x_err` = 0.
  - On a bad access, `x_rdata` = 0 and `x_err` = 1. An X from the ROM's default arm must never reach `x_rdata`.
  - `x_rdata` holds its last value while `x_rvalid` is 0.
- Conflict counter: increments on every cycle with `i_req` and `d_req` both high, independent of the arbitration mode. It saturates at all-ones and does not wrap.
- Back-to-back: a port may request and be granted on consecutive cycles, giving throughput 1 word/cycle per port when uncontended.

## Timing
- Reset values: `i_gnt`, `d_gnt` = 0 (grants are gated by `rst`); `i_rvalid`, `d_rvalid`, `i_err`, `d_err` = 0; `i_rdata`, `d_rdata` = 0; `rom_addr` = 0; `conflict_cnt` = 0; round-robin pointer = I-port-next.
- Latency is grant cycle + 1: the response is registered.
- Reset asserted mid-operation: an in-flight response is dropped, no `rvalid` is produced after reset releases, and the requester re-requests.
- Simultaneous requests: exactly one grant per cycle. The loser sees `x_gnt` = 0 and keeps requesting.
- A request deasserted without a grant is legal and leaves no side effect.

## Configuration
- `ROM_ARB_RR_EN` defined: round-robin arbitration.
  - A 1-bit last-grant pointer selects the winner on conflict: the port not granted most recently wins.
  - The pointer updates only on conflict cycles.
  - The pointer reset value makes the I-port win the first conflict.
- `ROM_ARB_RR_EN` undefined: fixed D-port priority. The pointer logic is not present.

## Structure
- Shared package `rom_arb_pkg`:
  - `port_e` enum {PORT_I, PORT_D};
  - `rom_rsp_t` struct {valid, err, data[31:0]};
  - constant `ROM_WORD_BYTES` = 4.
- One sub-module, `rom_arb_rsp_reg`: a per-port response register (valid/err/data capture with async reset), instantiated twice.

## Test plan
- Single I-port fetch: `i_req`=1, `i_addr`=0x14 → `i_gnt`=1 same cycle; next cycle `i_rvalid`=1, `i_rdata`=0x0C000011, `i_err`=0.
- Conflict in the default build: both ports request for 3 cycles, `i_addr`=0x00, `d_addr`=0x10 → D-port granted in cycle 0 (`d_rdata`=0x2404000A in cycle 1); I-port granted once `d_req` drops; `conflict_cnt`=3.
- Conflict with `ROM_ARB_RR_EN`: both ports request continuously for 4 cycles → grants alternate I, D, I, D; each port gets exactly 2 `rvalid` pulses.
- Misaligned and out-of-range accesses:
  - `d_addr`=0x06 → `d_rvalid`=1, `d_err`=1, `d_rdata`=0;
  - `i_addr`=0xF0 → `i_err`=1, `i_rdata`=0, and no X is visible on `i_rdata`.
- Reset mid-operation: I-port granted at 0x44, then `rst` is pulsed before the capture edge → after release, `i_rvalid`=0, `rom_addr`=0, `conflict_cnt`=0.
- Counter saturation with `CNT_W`=4: 20 conflict cycles → `conflict_cnt`=0xF and it stays at 0xF.
